counter_initiator: RTL
======================

Name: counter_initiator

Overview:
- Initiator-side controller for the 5-bit event counter; it is the block that drives rst_n-domain control pins start, wait_timer and flag, and consumes busy and count_value.
- Accepts transaction requests over a valid/ready channel and launches one counter run per request.
- Tracks the counter's busy handshake and returns the final count, or an error, over a valid/ready response channel.
- Keeps saturating transaction and error statistics for debug readout.

Parameters:
- ACK_TIMEOUT, 16, cycles allowed in WAIT_BUSY for busy to rise before a run is flagged as failed (legal range 2..65535).
- STAT_W, 8, width of the saturating statistics counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  initiator can accept a request.
- req_wait  input  16  wait_timer value for this run.
- req_flag  input  1  flag value for this run.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_count  output  5  captured count_value; 0 on error.
- rsp_err  output  1  1 = run did not complete (ack timeout or abort).
- abort  input  1  forces the current run to end with an error.
- start  output  1  one-cycle launch pulse to the counter.
- wait_timer  output  16  timer value driven to the counter.
- flag  output  1  flag driven to the counter.
- busy  input  1  counter run in progress.
- count_value  input  5  counter result.
- txn_cnt  output  STAT_W  completed responses, saturating.
- err_cnt  output  STAT_W  error responses, saturating.

Behaviour:
- Reset: rst_n low at a rising edge sets state IDLE and clears req_ready, rsp_valid, rsp_count, rsp_err, start, wait_timer, flag, txn_cnt, err_cnt and the ack counter to 0.
- Reset mid-run: the run is discarded, no response is issued, and start is low from the next edge.
- req_ready equals (state==IDLE). It is registered-state-derived, with no combinational path from req_valid.
- IDLE: a req_valid&&req_ready edge latches req_wait into wait_timer and req_flag into flag, then goes to LAUNCH.
- wait_timer and flag stay stable from LAUNCH until the exit from RESP. req_wait==0 is forwarded unchanged, with no special case.
- LAUNCH (1 cycle): start=1, clear the ack counter, then go to WAIT_BUSY.
- start is high in exactly one cycle per accepted request. The first start is high in the cycle after acceptance.
- WAIT_BUSY:
  - If abort, go to RESP with err.
  - Else if busy, go to RUN. Busy already high in the first WAIT_BUSY cycle counts as the ack.
  - Else increment the ack counter. When the counter reaches ACK_TIMEOUT-1, go to RESP with rsp_err=1, rsp_count=0.
  - abort has priority over busy in the same cycle.
- RUN:
  - If abort, go to RESP with rsp_err=1, rsp_count=0.
  - Else, when busy==0, capture count_value into rsp_count, set rsp_err=0 and go to RESP.
  - No timeout in RUN; abort is the only escape.
- RESP: rsp_valid=1, with rsp_count and rsp_err held stable until rsp_valid&&rsp_ready. On that handshake, go to IDLE.
- Back-to-back: a new request is acceptable in the cycle after the RESP handshake.
- Minimum request-to-response latency is 4 cycles (accept, LAUNCH, WAIT_BUSY sees busy, RUN sees busy low, then RESP).
- Statistics: on each RESP handshake, txn_cnt increments; err_cnt also increments if rsp_err. Both saturate at 2^STAT_W-1 with no wrap.
- abort outside WAIT_BUSY/RUN is ignored.

Test Plan:
- Reset then req_wait=0x0010, flag=1; counter model raises busy 1 cycle after start, drops it after 20 cycles with count_value=5 -> start high exactly once; wait_timer=0x0010, flag=1 held; rsp_count=5, rsp_err=0; txn_cnt=1, err_cnt=0.
- busy never rises, ACK_TIMEOUT=16 -> RESP entered 16 cycles after LAUNCH with rsp_err=1, rsp_count=0; err_cnt=1.
- abort pulsed during RUN with busy high -> next cycle RESP, rsp_err=1, rsp_count=0; a later request completes normally.
- rsp_ready held low 10 cycles -> rsp_valid, rsp_count and rsp_err stable; req_ready=0 throughout; no second start.
- rst_n low for 1 cycle mid-RUN -> all outputs 0 next edge, no response, stats cleared; a fresh request then works.
- 300 back-to-back error transactions with STAT_W=8 -> err_cnt and txn_cnt saturate at 255.

Source files
------------

// File: rtl/counter_initiator.sv
// Initiator-side controller for the 5-bit event counter: launches one counter run
// per request, tracks the busy handshake and returns the final count or an error.
module counter_initiator #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned STAT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_wait,
  input  logic              req_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [4:0]        rsp_count,
  output logic              rsp_err,
  input  logic              abort,
  output logic              start,
  output logic [15:0]       wait_timer,
  output logic              flag,
  input  logic              busy,
  input  logic [4:0]        count_value,
  output logic [STAT_W-1:0] txn_cnt,
  output logic [STAT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_RUN,
    S_RESP
  } state_t;

  // Last ack-counter value before the timeout fires; gives ACK_TIMEOUT-1 WAIT_BUSY cycles.
  localparam logic [15:0]       ACK_LAST = 16'(ACK_TIMEOUT - 2);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  state_t      state, state_nxt;
  logic [15:0] ack_cnt, ack_cnt_nxt;
  logic        accept;
  logic        ld_rsp;
  logic        rsp_err_nxt;
  logic [4:0]  rsp_count_nxt;
  logic        rsp_hs;

  assign accept = (state == S_IDLE) && req_valid && req_ready;
  assign rsp_hs = (state == S_RESP) && rsp_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt     = state;
    ack_cnt_nxt   = ack_cnt;
    ld_rsp        = 1'b0;
    rsp_err_nxt   = 1'b1;
    rsp_count_nxt = '0;

    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        ack_cnt_nxt = '0;
        state_nxt   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (abort) begin
          ld_rsp    = 1'b1;
          state_nxt = S_RESP;
        end else if (busy) begin
          state_nxt = S_RUN;
        end else if (ack_cnt == ACK_LAST) begin
          ld_rsp    = 1'b1;
          state_nxt = S_RESP;
        end else begin
          ack_cnt_nxt = ack_cnt + 16'd1;
        end
      end
      S_RUN: begin
        // Only abort can end a run early; a stuck busy waits forever by design.
        if (abort) begin
          ld_rsp    = 1'b1;
          state_nxt = S_RESP;
        end else if (!busy) begin
          ld_rsp        = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_count_nxt = count_value;
          state_nxt     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_hs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ack_cnt    <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_count  <= '0;
      rsp_err    <= 1'b0;
      start      <= 1'b0;
      wait_timer <= '0;
      flag       <= 1'b0;
      txn_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      ack_cnt   <= ack_cnt_nxt;
      // Handshake flags are registered from the next state, so they track state exactly.
      req_ready <= (state_nxt == S_IDLE);
      start     <= (state_nxt == S_LAUNCH);
      rsp_valid <= (state_nxt == S_RESP);

      if (accept) begin
        wait_timer <= req_wait;
        flag       <= req_flag;
      end

      if (ld_rsp) begin
        rsp_count <= rsp_count_nxt;
        rsp_err   <= rsp_err_nxt;
      end

      if (rsp_hs) begin
        if (txn_cnt != STAT_MAX) txn_cnt <= txn_cnt + 1'b1;
        if (rsp_err && (err_cnt != STAT_MAX)) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
